// File: rtl/move_cmd_queue.sv
// Button-driven move command queue: debounced presses capture sw into a FIFO, drained as paced strobes.
// Optional macro MOVE_CMD_REPEAT_EN adds auto-repeat while the button is held.
module move_cmd_queue #(
    parameter int DEPTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int GAP_CYCLES      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      btn,
    input  logic [3:0]                sw,
    output logic                      cmd_valid,
    output logic [3:0]                cmd,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty,
    output logic                      overflow
);

    localparam int AW  = $clog2(DEPTH);
    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [AW:0]     DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [DBW-1:0]  DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [GW-1:0]   GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic           btn_meta, btn_s;
    logic           db_level, db_flip, press_rise, push, pop, push_ok;
    logic [DBW-1:0] db_cnt;
    logic [3:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count_nxt;
    logic [1:0]     state;
    logic [GW-1:0]  gap_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            btn_meta <= btn;
            btn_s    <= btn_meta;
        end
    end

    // level flips only after DEBOUNCE_CYCLES consecutive samples disagree with it
    assign db_flip    = (btn_s != db_level) && (db_cnt == DB_LAST);
    assign press_rise = db_flip && btn_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_level <= 1'b0;
            db_cnt   <= '0;
        end else if (btn_s == db_level) begin
            db_cnt   <= '0;
        end else if (db_flip) begin
            db_level <= btn_s;
            db_cnt   <= '0;
        end else begin
            db_cnt   <= db_cnt + 1'b1;
        end
    end

`ifdef MOVE_CMD_REPEAT_EN
    localparam int RPT = 8 * DEBOUNCE_CYCLES;
    localparam int RW  = $clog2(RPT);
    localparam logic [RW-1:0] RPT_LAST = RW'(RPT - 1);
    logic [RW-1:0] rpt_cnt;
    logic          rpt_fire;

    assign rpt_fire = db_level && (rpt_cnt == RPT_LAST);
    assign push     = press_rise || rpt_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    rpt_cnt <= '0;
        else if (!db_level || rpt_fire) rpt_cnt <= '0;
        else                           rpt_cnt <= rpt_cnt + 1'b1;
    end
`else
    assign push = press_rise;
`endif

    assign pop     = (state == ST_ISSUE);
    assign push_ok = push && (!full || pop);

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop)      count_nxt = count + 1'b1;
        else if (!push_ok && pop) count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= sw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count    <= count_nxt;
            full     <= (count_nxt == DEPTH_C);
            empty    <= (count_nxt == '0);
            overflow <= overflow || (push && full && !pop);
        end
    end

    // strobe and head capture happen on the edge that leaves ISSUE, alongside the pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            gap_cnt   <= '0;
            cmd_valid <= 1'b0;
            cmd       <= 4'd0;
        end else begin
            cmd_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!empty) state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    cmd_valid <= 1'b1;
                    cmd       <= mem[rd_ptr];
                    if (GAP_CYCLES > 0) begin
                        state   <= ST_GAP;
                        gap_cnt <= GAP_LOAD;
                    end else begin
                        state   <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) state <= ST_IDLE;
                    else               gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
